// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
// NOP encoding, default widths, FSM states and a saturating counter helper.
package fetch_unit_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, instr} entries.
// Clear empties it in one cycle; pop on empty is ignored.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int W     = 28,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [W-1:0]  din,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_pop;

    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch responder: prefetch FSM, fetch PC and redirect handling.
// Optional FETCH_PERF_CNT_EN adds saturating fetched/flushed counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]       perf_fetched,
    output logic [15:0]       perf_flushed,
`endif
    input  logic              rom_rd,
    output logic [DATA_W-1:0] ROM_data,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_data
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t state, state_n;
    logic                     req_n;
    logic [ADDR_W-1:0]        addr_n;
    logic [ADDR_W-1:0]        pc, pc_n, pc_inc;
    logic [CW-1:0]            count, count_after;
    logic [ADDR_W+DATA_W-1:0] head;
    logic                     push, pop;

    fetch_fifo #(
        .W     (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (redirect),
        .din   ({imem_addr, imem_data}),
        .count (count),
        .head  (head)
    );

    // A redirect kills both the pop and any returning data in that cycle.
    assign instr_valid = (count != '0);
    assign pop         = rom_rd && instr_valid && !redirect;
    assign push        = (state == S_WAIT) && imem_ack && !redirect;
    assign count_after = count + CW'(1) - CW'(pop);
    assign pc_inc      = pc + ADDR_W'(1);
    assign ROM_data    = instr_valid ? head[DATA_W-1:0] : DATA_W'(NOP_INSTR);
    assign pc_out      = instr_valid ? head[ADDR_W+DATA_W-1:DATA_W] : RESET_PC;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            pc        <= RESET_PC;
        end else begin
            state     <= state_n;
            imem_req  <= req_n;
            imem_addr <= addr_n;
            pc        <= pc_n;
        end
    end

    always_comb begin
        state_n = state;
        req_n   = imem_req;
        addr_n  = imem_addr;
        pc_n    = pc;
        unique case (state)
            S_IDLE: begin
                if (redirect) begin
                    pc_n = redirect_addr;
                end else if (count < CW'(FIFO_DEPTH)) begin
                    req_n   = 1'b1;
                    addr_n  = pc;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_n = redirect_addr;
                    if (imem_ack) begin
                        req_n   = 1'b0;
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_DROP;
                    end
                end else if (imem_ack) begin
                    pc_n = pc_inc;
                    if (count_after < CW'(FIFO_DEPTH)) begin
                        addr_n = pc_inc;
                    end else begin
                        req_n   = 1'b0;
                        state_n = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (redirect) pc_n = redirect_addr;
                if (imem_ack) begin
                    req_n   = 1'b0;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    logic flush_evt;

    assign flush_evt = redirect && (instr_valid || state == S_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= 16'h0000;
            perf_flushed <= 16'h0000;
        end else begin
            if (push) perf_fetched <= sat_inc16(perf_fetched);
            if (flush_evt) perf_flushed <= sat_inc16(perf_flushed);
        end
    end
`else
    // no performance counters in this build
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queue-based model of the fetched stream
// and a memory model returning 16'hA000 | addr after a programmable delay.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_rd = 1'b0;
    logic        redirect = 1'b0;
    logic [11:0] redirect_addr = 12'h000;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic [15:0] ROM_data;
    logic        instr_valid;
    logic [11:0] pc_out;
    logic        imem_req;
    logic [11:0] imem_addr;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .rom_rd        (rom_rd),
        .ROM_data      (ROM_data),
        .instr_valid   (instr_valid),
        .pc_out        (pc_out),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // memory: ack mem_delay cycles after a request is first seen
    int mem_delay = 0;
    int mem_cnt = 0;
    bit mem_busy = 0;

    always @(negedge clk) begin
        if (!imem_req) begin
            imem_ack = 1'b0;
            mem_busy = 0;
        end else begin
            if (!mem_busy || imem_ack) begin
                mem_busy = 1;
                mem_cnt = mem_delay;
            end
            if (mem_cnt == 0) begin
                imem_ack = 1'b1;
                imem_data = 16'hA000 | {4'h0, imem_addr};
            end else begin
                imem_ack = 1'b0;
                mem_cnt--;
            end
        end
    end

    // model: queue of PCs that must be presented, in order
    logic [11:0] q[$];
    logic [11:0] exp_fetch = 12'h000;
    bit          drop_next = 0;
    bit          had;
    logic        pre_req = 1'b0;
    logic        pre_ack = 1'b0;
    logic        pre_rst = 1'b1;
    logic [11:0] pre_addr = 12'h000;

    always @(posedge clk) begin
        pre_req = imem_req;
        pre_ack = imem_ack;
        pre_rst = rst;
        pre_addr = imem_addr;
        if (rst) begin
            q.delete();
            exp_fetch = 12'h000;
            drop_next = 0;
        end else if (redirect) begin
            q.delete();
            exp_fetch = redirect_addr;
            drop_next = imem_req && !imem_ack;
        end else begin
            had = (q.size() != 0);
            if (imem_req && imem_ack) begin
                if (drop_next) begin
                    drop_next = 0;
                end else begin
                    chk("fetch_addr", imem_addr, exp_fetch);
                    q.push_back(imem_addr);
                    exp_fetch = exp_fetch + 12'd1;
                end
            end
            if (rom_rd && had) void'(q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (q.size() != 0) begin
            chk("instr_valid", instr_valid, 1);
            chk("pc_out", pc_out, q[0]);
            chk("rom_data", ROM_data, 16'hA000 | {4'h0, q[0]});
        end else begin
            chk("instr_valid", instr_valid, 0);
            chk("rom_data_nop", ROM_data, 0);
        end
        chk("fifo_bound", q.size() <= 4, 1);
        if (pre_req && !pre_ack && !pre_rst) begin
            chk("req_hold", imem_req, 1);
            chk("addr_hold", imem_addr, pre_addr);
        end
    end

    logic [11:0] t6_pc [2];
    int k;
    bit found;

    initial begin
        t6_pc[0] = 12'hFFF;
        t6_pc[1] = 12'h000;

        // 1: reset values and first request
        step();
        step();
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 12'h000);
        chk("rst_valid", instr_valid, 0);
        chk("rst_data", ROM_data, 16'h0000);
        chk("rst_pc", pc_out, 12'h000);
        rst = 1'b0;
        step();
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 12'h000);
        chk("first_valid", instr_valid, 0);
        step();
        chk("lat_valid", instr_valid, 1);
        chk("lat_data", ROM_data, 16'hA000);
        chk("lat_pc", pc_out, 12'h000);

        // 2: fill without popping
        repeat (8) step();
        chk("full_req", imem_req, 0);
        chk("full_cnt", q.size(), 4);
        chk("full_head", ROM_data, 16'hA000);

        // 3: continuous pop
        rom_rd = 1'b1;
        k = 0;
        for (int i = 0; i < 60 && k < 6; i++) begin
            if (instr_valid) begin
                chk("t3_data", ROM_data, 32'hA000 + k);
                chk("t3_pc", pc_out, k);
                k++;
            end
            step();
        end
        rom_rd = 1'b0;
        chk("t3_pops", k, 6);
        repeat (10) step();

        // 4: redirect while waiting on a slow ack
        mem_delay = 3;
        rom_rd = 1'b1;
        step();
        rom_rd = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_req) found = 1;
            else step();
        end
        chk("t4_req_seen", found, 1);
        redirect = 1'b1;
        redirect_addr = 12'h040;
        step();
        redirect = 1'b0;
        chk("t4_flushed", instr_valid, 0);
        chk("t4_drop_req", imem_req, 1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_req && imem_addr == 12'h040) found = 1;
            else step();
        end
        chk("t4_new_addr", found, 1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (instr_valid) found = 1;
            else step();
        end
        chk("t4_valid", found, 1);
        chk("t4_data", ROM_data, 16'hA040);
        chk("t4_pc", pc_out, 12'h040);

        // 5: redirect coinciding with ack
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_ack) found = 1;
            else step();
        end
        chk("t5_ack_seen", found, 1);
        redirect = 1'b1;
        redirect_addr = 12'h080;
        step();
        redirect = 1'b0;
        chk("t5_flushed", instr_valid, 0);
        chk("t5_idle", imem_req, 0);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (instr_valid) found = 1;
            else step();
        end
        chk("t5_valid", found, 1);
        chk("t5_data", ROM_data, 16'hA080);
        chk("t5_pc", pc_out, 12'h080);

        // 6: PC wrap
        mem_delay = 0;
        redirect = 1'b1;
        redirect_addr = 12'hFFF;
        step();
        redirect = 1'b0;
        rom_rd = 1'b1;
        k = 0;
        for (int i = 0; i < 40 && k < 2; i++) begin
            if (instr_valid) begin
                chk("t6_pc", pc_out, t6_pc[k]);
                chk("t6_data", ROM_data, 16'hA000 | {4'h0, t6_pc[k]});
                k++;
            end
            step();
        end
        rom_rd = 1'b0;
        chk("t6_pops", k, 2);
        repeat (10) step();

        // reset with a request outstanding
        mem_delay = 3;
        rom_rd = 1'b1;
        step();
        rom_rd = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_req) found = 1;
            else step();
        end
        chk("t7_req_seen", found, 1);
        rst = 1'b1;
        step();
        chk("t7_req", imem_req, 0);
        chk("t7_addr", imem_addr, 12'h000);
        chk("t7_valid", instr_valid, 0);
        chk("t7_data", ROM_data, 16'h0000);
        chk("t7_pc", pc_out, 12'h000);
        rst = 1'b0;
        step();
        chk("t7_restart_req", imem_req, 1);
        chk("t7_restart_addr", imem_addr, 12'h000);
        repeat (12) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
